// File: rtl/hc153_pkg.sv
// Shared encodings and constants for the HC153 scan controller.
package hc153_pkg;

    localparam int NUM_CH         = 4;
    localparam int CH_W           = 2;
    localparam int SETTLE_CYC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hc153_scan_ctrl_if.sv
// Requester, mux-control and consumer signals of the scan controller.
interface hc153_scan_ctrl_if;
    import hc153_pkg::*;

    logic                scan_en;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     mux_sel;
    logic                mux_disable;
    logic                mux_out;
    logic                out_valid;
    logic                out_ready;
    logic                out_bit;
    logic [CH_W-1:0]     out_ch;

    // master: the controller itself
    modport master (
        input  scan_en, req, mux_out, out_ready,
        output grant, mux_sel, mux_disable, out_valid, out_bit, out_ch
    );

    // slave: requesters, mux and consumer around the controller
    modport slave (
        output scan_en, req, mux_out, out_ready,
        input  grant, mux_sel, mux_disable, out_valid, out_bit, out_ch
    );
endinterface

// File: rtl/hc153_rr_pick.sv
// Round-robin pick: first set request searching upward from last+1, wrapping 3->0.
module hc153_rr_pick
    import hc153_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   ch,
    output logic              any
);

    logic [CH_W-1:0] w_idx [NUM_CH];
    logic [NUM_CH-1:0] w_rot;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign w_idx[gi] = last + CH_W'(gi + 1);
            assign w_rot[gi] = req[w_idx[gi]];
        end
    endgenerate

    // Lowest rotated offset wins, so scan from the far end down.
    always_comb begin
        ch  = '0;
        any = |req;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) ch = w_idx[k];
        end
    end

endmodule

// File: rtl/hc153_scan_ctrl.sv
// Round-robin sequencer: selects a mux channel, waits SETTLE_CYC, samples,
// and hands the bit to a consumer over valid/ready.
module hc153_scan_ctrl
    import hc153_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    hc153_scan_ctrl_if.master  bus
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CH_W-1:0]     r_last;
    logic [CH_W-1:0]     r_mux_sel;
    logic                r_mux_disable;
    logic [NUM_CH-1:0]   r_grant;
    logic                r_out_valid;
    logic                r_out_bit;
    logic [CH_W-1:0]     r_out_ch;

    logic [CH_W-1:0]     w_ch;
    logic                w_any;

    hc153_rr_pick u_pick (
        .req  (bus.req),
        .last (r_last),
        .ch   (w_ch),
        .any  (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last        <= CH_W'(NUM_CH - 1);
            r_mux_sel     <= '0;
            r_mux_disable <= 1'b1;
            r_grant       <= '0;
            r_out_valid   <= 1'b0;
            r_out_bit     <= 1'b0;
            r_out_ch      <= '0;
        end else begin
            r_grant <= '0;
            case (r_state)
                IDLE: begin
                    if (bus.scan_en && w_any) begin
                        r_mux_sel     <= w_ch;
                        r_mux_disable <= 1'b0;
                        r_cnt         <= CNT_W'(SETTLE_CYC - 1);
                        r_last        <= w_ch;
                        r_state       <= SETTLE;
                    end else begin
                        r_mux_disable <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Sampled while still enabled; the disable takes effect afterwards.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_out_bit     <= bus.mux_out;
                        r_out_ch      <= r_mux_sel;
                        r_mux_disable <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_grant       <= onehot(r_mux_sel);
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.mux_sel     = r_mux_sel;
    assign bus.mux_disable = r_mux_disable;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_bit     = r_out_bit;
    assign bus.out_ch      = r_out_ch;

endmodule

// File: tb/tb_hc153_scan_ctrl.sv
// Directed bench for hc153_scan_ctrl with a behavioural HC153 mux on the bus.
module tb_hc153_scan_ctrl;
    import hc153_pkg::*;

    localparam int N = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] mux_data;
    int         n_cmp;
    int         n_bad;
    int         cyc;

    hc153_scan_ctrl_if bus ();

    // HC153: disable forces 0, otherwise select one of four data bits
    assign bus.mux_out = bus.mux_disable ? 1'b0 : mux_data[bus.mux_sel];

    hc153_scan_ctrl #(.SETTLE_CYC(N), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cyc %0d)", tag, obs, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.grant != 4'b0000) break;
            tick();
        end
        check_val({tag, "_seen"}, 32'(bus.grant != 4'b0000), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_ch [5];
        int prev;
        logic [3:0] dv;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        bus.scan_en   = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        mux_data      = 4'b0000;

        // Reset and quiet idle
        do_reset();
        check_val("rst_dis",   32'(bus.mux_disable), 32'd1);
        check_val("rst_valid", 32'(bus.out_valid),   32'd0);
        check_val("rst_grant", 32'(bus.grant),       32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("idle_sel", 32'(bus.mux_sel), 32'd0);
            check_val("idle_dis", 32'(bus.mux_disable), 32'd1);
        end

        // Single request on channel 2 with latency check
        bus.req  = 4'b0100;
        mux_data = 4'b0100;
        tick();
        check_val("c1_sel", 32'(bus.mux_sel), 32'd2);
        check_val("c1_dis", 32'(bus.mux_disable), 32'd0);
        check_val("c1_valid", 32'(bus.out_valid), 32'd0);
        bus.req = 4'b0000;
        tick();
        check_val("c2_dis", 32'(bus.mux_disable), 32'd0);
        check_val("c2_grant", 32'(bus.grant), 32'd0);
        tick();
        check_val("c3_valid", 32'(bus.out_valid), 32'd1);
        check_val("c3_bit",   32'(bus.out_bit),   32'd1);
        check_val("c3_ch",    32'(bus.out_ch),    32'd2);
        check_val("c3_grant", 32'(bus.grant),     32'h4);
        check_val("c3_dis",   32'(bus.mux_disable), 32'd1);

        // Backpressure: data flips to 0 and a new request waits
        mux_data = 4'b0000;
        bus.req  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_valid", 32'(bus.out_valid), 32'd1);
            check_val("bp_bit",   32'(bus.out_bit),   32'd1);
            check_val("bp_ch",    32'(bus.out_ch),    32'd2);
            check_val("bp_grant", 32'(bus.grant),     32'd0);
            check_val("bp_dis",   32'(bus.mux_disable), 32'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        check_val("hs_valid", 32'(bus.out_valid), 32'd0);
        check_val("hs_dis",   32'(bus.mux_disable), 32'd1);
        tick();
        check_val("rearb_sel", 32'(bus.mux_sel), 32'd0);
        check_val("rearb_dis", 32'(bus.mux_disable), 32'd0);
        bus.req = 4'b0000;
        tick();
        tick();
        check_val("zero_grant", 32'(bus.grant), 32'h1);
        check_val("zero_bit",   32'(bus.out_bit), 32'd0);
        tick();
        check_val("zero_pulse", 32'(bus.grant), 32'd0);

        // Round-robin from reset with all four requests held
        do_reset();
        exp_ch   = '{0, 1, 2, 3, 0};
        dv       = 4'b1010;
        mux_data = dv;
        bus.req  = 4'b1111;
        prev     = -1;
        for (int i = 0; i < 5; i++) begin
            wait_grant("rr");
            check_val("rr_ch",  32'(bus.out_ch),  32'(exp_ch[i]));
            check_val("rr_bit", 32'(bus.out_bit), 32'(dv[exp_ch[i]]));
            if (prev >= 0) check_val("rr_gap", 32'(cyc - prev), 32'(N + 2));
            prev = cyc;
            tick();
            check_val("rr_pulse", 32'(bus.grant), 32'd0);
        end
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        tick();

        // From last=3, req=1001 serves 0 then 3
        do_reset();
        bus.req = 4'b1001;
        wait_grant("p0");
        check_val("p0_ch", 32'(bus.out_ch), 32'd0);
        tick();
        wait_grant("p3");
        check_val("p3_ch", 32'(bus.out_ch), 32'd3);
        bus.req = 4'b0000;
        tick();
        tick();

        // scan_en and req drop during SETTLE; transaction still completes
        bus.req = 4'b0010;
        tick();
        check_val("mid_dis", 32'(bus.mux_disable), 32'd0);
        bus.req     = 4'b0000;
        bus.scan_en = 1'b0;
        tick();
        tick();
        check_val("mid_grant", 32'(bus.grant), 32'h2);
        check_val("mid_ch",    32'(bus.out_ch), 32'd1);
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("noscan_dis", 32'(bus.mux_disable), 32'd1);
        end

        // Reset during SETTLE aborts without grant or valid
        bus.scan_en = 1'b1;
        bus.req     = 4'b0100;
        tick();
        check_val("abort_pre_dis", 32'(bus.mux_disable), 32'd0);
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        tick();
        check_val("abort_dis",   32'(bus.mux_disable), 32'd1);
        check_val("abort_valid", 32'(bus.out_valid),   32'd0);
        check_val("abort_grant", 32'(bus.grant),       32'd0);
        check_val("abort_sel",   32'(bus.mux_sel),     32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("post_grant", 32'(bus.grant), 32'd0);
            check_val("post_valid", 32'(bus.out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
